sync_fifo_prog: RTL and testbench

Single-clock, parametrised successor to the team's async FIFO. It generalises data width and depth and adds a selectable read mode (standard or first-word-fall-through). It also adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It is used wherever producer and consumer share one clock domain.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 33 +++
 rtl/sync_fifo_prog.sv | 144 ++++++++++++++
 tb/tb_sync_fifo_prog.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO family.
//   FIFO_DSIZE / FIFO_ASIZE : default data width and address width
//   MODE_STD / MODE_FWFT    : read-mode selectors for the FWFT parameter
//   fifo_depth()            : number of entries addressed by an ASIZE-bit address
package fifo_pkg;

  localparam int unsigned FIFO_DSIZE = 8;
  localparam int unsigned FIFO_ASIZE = 4;

  localparam int unsigned MODE_STD  = 0;
  localparam int unsigned MODE_FWFT = 1;

  function automatic int unsigned fifo_depth(input int unsigned asize);
    return 32'(1) << asize;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for sync_fifo_prog.
//   clk     : write clock
//   we      : write enable, stores wdata at waddr on posedge clk
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address
//   rdata_c : combinational read of the entry at raddr
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = FIFO_DSIZE,
  parameter int unsigned ASIZE = FIFO_ASIZE
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata_c
);

  localparam int unsigned DEPTH = fifo_depth(ASIZE);

  logic [DSIZE-1:0] mem [DEPTH];

  // Storage is never reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with selectable standard / first-word-fall-through read,
// occupancy count, programmable almost flags, sticky error flags and flush.
//   clk, rst      : clock and synchronous active-high reset
//   wdata, winc   : write data and write request
//   rinc          : read request
//   flush         : discard all stored entries
//   clr_err       : clear overflow/underflow
//   rdata         : read data (registered in both modes)
//   wfull, rempty : count == DEPTH / count == 0
//   almost_full   : count >= AF_LEVEL
//   almost_empty  : count <= AE_LEVEL
//   count         : occupancy 0..DEPTH
//   overflow      : sticky, write attempted while full
//   underflow     : sticky, read attempted while empty
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE    = FIFO_DSIZE,
  parameter int unsigned ASIZE    = FIFO_ASIZE,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = MODE_STD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic             flush,
  input  logic             clr_err,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned DEPTH = fifo_depth(ASIZE);
  localparam int unsigned PW    = ASIZE + 1;

  // Elaboration-time range checks on the threshold parameters.
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
    $error("sync_fifo_prog: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
  end
  if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
    $error("sync_fifo_prog: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
  end

  logic [PW-1:0]    wptr, rptr, wptr_n, rptr_n;
  logic [PW-1:0]    count_n;
  logic             w_acc, r_acc;
  logic             ovf_n, unf_n;
  logic [ASIZE-1:0] raddr;
  logic [DSIZE-1:0] mem_rd;
  logic [DSIZE-1:0] rdata_n;

  fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk     (clk),
    .we      (w_acc & ~rst),
    .waddr   (wptr[ASIZE-1:0]),
    .wdata   (wdata),
    .raddr   (raddr),
    .rdata_c (mem_rd)
  );

  // Next-state: accept decode, pointers, occupancy and sticky errors.
  always_comb begin
    w_acc   = winc & ~wfull  & ~flush;
    r_acc   = rinc & ~rempty & ~flush;
    wptr_n  = wptr;
    rptr_n  = rptr;
    count_n = count;
    ovf_n   = overflow;
    unf_n   = underflow;

    if (flush) begin
      wptr_n  = '0;
      rptr_n  = '0;
      count_n = '0;
    end else begin
      if (w_acc) wptr_n = wptr + PW'(1);
      if (r_acc) rptr_n = rptr + PW'(1);
      if (w_acc && !r_acc)      count_n = count + PW'(1);
      else if (r_acc && !w_acc) count_n = count - PW'(1);
    end

    // Clear first so a same-cycle error wins.
    if (clr_err) begin
      ovf_n = 1'b0;
      unf_n = 1'b0;
    end
    if (winc && wfull  && !flush) ovf_n = 1'b1;
    if (rinc && rempty && !flush) unf_n = 1'b1;
  end

  // Read path: FWFT pre-loads the head that will be current after this edge,
  // bypassing wdata when the write lands on that slot (write into empty FIFO).
  always_comb begin
    rdata_n = rdata;
    if (FWFT == MODE_FWFT) begin
      raddr = rptr_n[ASIZE-1:0];
      if (w_acc && (wptr[ASIZE-1:0] == rptr_n[ASIZE-1:0])) rdata_n = wdata;
      else                                                  rdata_n = mem_rd;
    end else begin
      raddr = rptr[ASIZE-1:0];
      if (r_acc) rdata_n = mem_rd;
    end
  end

  // State and output registers; flags are decoded from the next count so
  // they line up with count itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rdata        <= '0;
    end else begin
      wptr         <= wptr_n;
      rptr         <= rptr_n;
      count        <= count_n;
      wfull        <= (count_n == PW'(DEPTH));
      rempty       <= (count_n == '0);
      almost_full  <= (count_n >= PW'(AF_LEVEL));
      almost_empty <= (count_n <= PW'(AE_LEVEL));
      overflow     <= ovf_n;
      underflow    <= unf_n;
      rdata        <= rdata_n;
    end
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench: one standard-mode and one FWFT-mode instance share the
// same stimulus and are compared every cycle against a queue-based model.
module tb_sync_fifo_prog;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 12;
  localparam int unsigned AE    = 2;

  logic       clk;
  logic       rst, winc, rinc, flush, clr_err;
  logic [7:0] wdata;

  logic [7:0] s_rdata, f_rdata;
  logic       s_wfull, s_rempty, s_af, s_ae, s_ovf, s_unf;
  logic       f_wfull, f_rempty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] s_count, f_count;

  int n_tests;
  int n_fail;
  bit chk_en;

  logic [7:0] q[$];
  bit         m_ovf, m_unf;
  logic [7:0] m_rd;

  sync_fifo_prog #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .flush(flush),
    .clr_err(clr_err), .rdata(s_rdata), .wfull(s_wfull), .rempty(s_rempty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_prog #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .flush(flush),
    .clr_err(clr_err), .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model of one clock edge, using the inputs held across it.
  task automatic model_edge();
    bit full, empty;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rd  = 8'h00;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (clr_err) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (winc && full)  m_ovf = 1'b1;
        if (rinc && empty) m_unf = 1'b1;
        if (rinc && !empty) m_rd = q.pop_front();
        if (winc && !full)  q.push_back(wdata);
      end
    end
  endtask

  task automatic step(input bit r_st, input bit w, input logic [7:0] wd,
                      input bit r, input bit fl, input bit ce);
    rst = r_st; winc = w; wdata = wd; rinc = r; flush = fl; clr_err = ce;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("std_count",   32'(s_count),  32'(q.size()));
      chk("std_wfull",   32'(s_wfull),  32'(q.size() == DEPTH));
      chk("std_rempty",  32'(s_rempty), 32'(q.size() == 0));
      chk("std_afull",   32'(s_af),     32'(q.size() >= AF));
      chk("std_aempty",  32'(s_ae),     32'(q.size() <= AE));
      chk("std_ovf",     32'(s_ovf),    32'(m_ovf));
      chk("std_unf",     32'(s_unf),    32'(m_unf));
      chk("std_rdata",   32'(s_rdata),  32'(m_rd));
      chk("fwft_count",  32'(f_count),  32'(q.size()));
      chk("fwft_wfull",  32'(f_wfull),  32'(q.size() == DEPTH));
      chk("fwft_rempty", 32'(f_rempty), 32'(q.size() == 0));
      chk("fwft_afull",  32'(f_af),     32'(q.size() >= AF));
      chk("fwft_aempty", 32'(f_ae),     32'(q.size() <= AE));
      chk("fwft_ovf",    32'(f_ovf),    32'(m_ovf));
      chk("fwft_unf",    32'(f_unf),    32'(m_unf));
      if (q.size() > 0) chk("fwft_head", 32'(f_rdata), 32'(q[0]));
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_rd    = 8'h00;
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; flush = 1'b0; clr_err = 1'b0; wdata = 8'h00;

    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    chk("rst_count",  32'(s_count),  32'd0);
    chk("rst_rempty", 32'(s_rempty), 32'd1);
    chk("rst_aempty", 32'(s_ae),     32'd1);
    chk("rst_rdata",  32'(s_rdata),  32'h00);

    // Fill with 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 10) chk("afull_at11", 32'(s_af), 32'd0);
      if (i == 11) chk("afull_at12", 32'(s_af), 32'd1);
    end
    chk("full_count", 32'(s_count), 32'd16);
    chk("full_wfull", 32'(s_wfull), 32'd1);

    // Drain in order.
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      if (k == 1)  chk("first_rdata", 32'(s_rdata), 32'h00);
      if (k == 13) chk("aempty_at3",  32'(s_ae),    32'd0);
      if (k == 14) chk("aempty_at2",  32'(s_ae),    32'd1);
    end
    chk("last_rdata",   32'(s_rdata),  32'h0F);
    chk("drain_rempty", 32'(s_rempty), 32'd1);

    // Overflow on a full FIFO, sticky until clr_err.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(32'h40 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("ovf_count", 32'(s_count), 32'd16);
    chk("ovf_set",   32'(s_ovf),   32'd1);
    idle();
    chk("ovf_sticky", 32'(s_ovf), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(s_ovf), 32'd0);

    // Down to 5 entries, then simultaneous read/write across the wrap.
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("mid_count", 32'(s_count), 32'd5);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(32'h80 + i), 1'b1, 1'b0, 1'b0);
    chk("wrap_count", 32'(s_count), 32'd5);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("wrap_last_rdata", 32'(s_rdata), 32'h89);

    // FWFT fall-through of the first write, then underflow.
    step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("fwft_3c_rempty", 32'(f_rempty), 32'd0);
    chk("fwft_3c_rdata",  32'(f_rdata),  32'h3C);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    chk("unf_set",      32'(f_unf),   32'd1);
    chk("unf_wr_count", 32'(s_count), 32'd1);
    chk("fwft_5a",      32'(f_rdata), 32'h5A);

    // Flush with a concurrent write at count 9.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(32'h60 + i), 1'b0, 1'b0, 1'b0);
    chk("pre_flush_count", 32'(s_count), 32'd9);
    step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    chk("flush_count",  32'(s_count),  32'd0);
    chk("flush_rempty", 32'(s_rempty), 32'd1);
    chk("flush_aempty", 32'(s_ae),     32'd1);
    chk("flush_unf",    32'(s_unf),    32'd1);
    idle();
    chk("flush_noentry", 32'(s_count), 32'd0);

    // clr_err with a same-cycle underflow: set wins.
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("unf_setwins", 32'(s_unf), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("unf_clr", 32'(s_unf), 32'd0);

    // Mid-stream reset with pending errors and entries.
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(32'h10 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    chk("rst2_count",  32'(s_count),  32'd0);
    chk("rst2_unf",    32'(s_unf),    32'd0);
    chk("rst2_rempty", 32'(s_rempty), 32'd1);
    chk("rst2_rdata",  32'(s_rdata),  32'h00);

    // Traffic after reset.
    step(1'b0, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hC2, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("post_rst_rdata", 32'(s_rdata), 32'hC2);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
